// File: rtl/max_unpool_if.sv
// Pooled-value stream into the max-unpool stage: one value plus its 2x2 argmax index per beat.
// The source drives valid/data/idx and the unpool stage returns ready.
interface max_unpool_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_idx;

    modport master (
        output in_valid,
        output in_data,
        output in_idx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_idx,
        output in_ready
    );
endinterface

// File: rtl/max_unpool.sv
// Inverse 2x2/stride-2 max pool: scatters each pooled value to its argmax cell of a
// 2x-upsampled map held in registers; the other three cells of every window stay zero.
module max_unpool #(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned IN_SIZE    = 4,
    localparam int unsigned OUT_SIZE   = 2 * IN_SIZE,
    localparam int unsigned CNT_W      = $clog2(IN_SIZE * IN_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    max_unpool_if.slave           in_if,
    output logic [DATA_WIDTH-1:0] ofmap [0:OUT_SIZE-1][0:OUT_SIZE-1],
    output logic                  done_unpool
);
    localparam int unsigned RC_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int unsigned OW     = $clog2(OUT_SIZE);
    localparam int unsigned BEATS  = IN_SIZE * IN_SIZE;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PROCESS = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [RC_W-1:0]  row_q;
    logic [RC_W-1:0]  col_q;
    logic [CNT_W-1:0] count_q;

    logic             accept_c;
    logic             last_beat_c;
    logic [OW-1:0]    wr_row_c;
    logic [OW-1:0]    wr_col_c;

    // Beat handshake and the target cell inside the current window
    always_comb begin
        accept_c    = in_if.in_valid && in_if.in_ready && (state_q == S_PROCESS);
        last_beat_c = accept_c && (count_q == CNT_W'(BEATS - 1));
        wr_row_c    = OW'({row_q, 1'b0}) + OW'(in_if.in_idx[1]);
        wr_col_c    = OW'({col_q, 1'b0}) + OW'(in_if.in_idx[0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion beats an abort when en drops on the final accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_PROCESS;
                end
            end
            S_PROCESS: begin
                if (last_beat_c) begin
                    state_d = S_DONE;
                end else if (!en) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered status outputs track the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_if.in_ready <= 1'b0;
            done_unpool    <= 1'b0;
        end else begin
            in_if.in_ready <= (state_d == S_PROCESS);
            done_unpool    <= (state_d == S_DONE);
        end
    end

    // Raster position of the next pooled beat; cleared at frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else if ((state_q == S_IDLE) && en) begin
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else if (accept_c) begin
            count_q <= count_q + CNT_W'(1);
            if (col_q == RC_W'(IN_SIZE - 1)) begin
                col_q <= '0;
                row_q <= row_q + RC_W'(1);
            end else begin
                col_q <= col_q + RC_W'(1);
            end
        end
    end

    // Map storage: wiped at frame start, one cell written per accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
                for (int j = 0; j < OUT_SIZE; j++) begin
                    ofmap[i][j] <= '0;
                end
            end
        end else if ((state_q == S_IDLE) && en) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
                for (int j = 0; j < OUT_SIZE; j++) begin
                    ofmap[i][j] <= '0;
                end
            end
        end else if (accept_c) begin
            ofmap[wr_row_c][wr_col_c] <= in_if.in_data;
        end
    end
endmodule

// File: tb/tb_max_unpool.sv
// Directed/randomised bench for max_unpool against a beat-index based reference map.
module tb_max_unpool;
    localparam int unsigned DW  = 16;
    localparam int unsigned IN  = 4;
    localparam int unsigned OUT = 2 * IN;
    localparam int unsigned NB  = IN * IN;

    logic          clk;
    logic          reset;
    logic          en;
    logic [DW-1:0] ofmap [0:OUT-1][0:OUT-1];
    logic          done_unpool;

    max_unpool_if #(.DATA_WIDTH(DW)) bus ();

    max_unpool #(.DATA_WIDTH(DW), .IN_SIZE(IN)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .in_if       (bus),
        .ofmap       (ofmap),
        .done_unpool (done_unpool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    logic [DW-1:0] exp_map [0:OUT-1][0:OUT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < OUT; i++)
            for (int j = 0; j < OUT; j++)
                exp_map[i][j] = '0;
        k = 0;
    endtask

    // Beat k covers pooled window (k/IN, k%IN); idx picks {row,col} inside it
    task automatic model_write(input logic [DW-1:0] d, input logic [1:0] ix);
        int r;
        int c;
        r = 2 * (k / IN) + int'(ix[1]);
        c = 2 * (k % IN) + int'(ix[0]);
        exp_map[r][c] = d;
        k++;
    endtask

    task automatic check_map(input string tag);
        for (int i = 0; i < OUT; i++)
            for (int j = 0; j < OUT; j++)
                chk($sformatf("%s[%0d][%0d]", tag, i, j), 32'(ofmap[i][j]), 32'(exp_map[i][j]));
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [1:0] ix);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_idx   = ix;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        model_write(d, ix);
        bus.in_valid = 1'b0;
    endtask

    task automatic start_frame();
        en = 1'b1;
        tick();
        model_clear();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [1:0]    ix;

        reset = 1'b1;
        en    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_idx   = '0;
        model_clear();
        tick();
        tick();
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_done", 32'(done_unpool), 32'd0);
        check_map("rst_map");
        reset = 1'b0;
        tick();

        // Full back-to-back frame, data k+1, idx k%4
        start_frame();
        chk("t2_ready", 32'(bus.in_ready), 32'd1);
        for (int b = 0; b < NB; b++) begin
            if (b == NB - 1) chk("t2_done_early", 32'(done_unpool), 32'd0);
            beat(DW'(b + 1), 2'(b % 4));
        end
        chk("t2_done", 32'(done_unpool), 32'd1);
        chk("t2_ready_done", 32'(bus.in_ready), 32'd0);
        chk("t2_cell00", 32'(ofmap[0][0]), 32'd1);
        chk("t2_cell03", 32'(ofmap[0][3]), 32'd2);
        chk("t2_cell23", 32'(ofmap[2][3]), 32'd6);
        check_map("t2_map");
        tick();
        chk("t2_done_hold", 32'(done_unpool), 32'd1);
        en = 1'b0;
        tick();
        chk("t2_done_clr", 32'(done_unpool), 32'd0);
        check_map("t2_map_held");

        // Same frame with random bubbles between beats
        start_frame();
        for (int b = 0; b < NB; b++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            chk("t3_no_done", 32'(done_unpool), 32'd0);
            beat(DW'(b + 1), 2'(b % 4));
        end
        chk("t3_done", 32'(done_unpool), 32'd1);
        check_map("t3_map");
        en = 1'b0;
        tick();

        // Abort after five random beats, then re-enable
        start_frame();
        for (int b = 0; b < 5; b++) begin
            d  = DW'($urandom);
            ix = 2'($urandom);
            beat(d, ix);
        end
        en = 1'b0;
        tick();
        chk("t4_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_done", 32'(done_unpool), 32'd0);
        check_map("t4_partial");
        start_frame();
        check_map("t4_cleared");
        d  = DW'($urandom_range(1, 65535));
        ix = 2'($urandom);
        beat(d, ix);
        chk("t4_first_cell", 32'(ofmap[ix[1]][ix[0]]), 32'(d));
        check_map("t4_restart");
        en = 1'b0;
        tick();

        // Bottom-right window with an all-ones value
        start_frame();
        for (int b = 0; b < NB - 1; b++) beat(DW'($urandom), 2'($urandom));
        beat(16'hFFFF, 2'd3);
        chk("t5_77", 32'(ofmap[7][7]), 32'hFFFF);
        chk("t5_66", 32'(ofmap[6][6]), 32'd0);
        chk("t5_67", 32'(ofmap[6][7]), 32'd0);
        chk("t5_76", 32'(ofmap[7][6]), 32'd0);
        check_map("t5_map");
        en = 1'b0;
        tick();

        // en drops on the same cycle as the final accept
        start_frame();
        for (int b = 0; b < NB - 1; b++) beat(DW'($urandom), 2'($urandom));
        en = 1'b0;
        beat(DW'($urandom), 2'($urandom));
        chk("t6_done", 32'(done_unpool), 32'd1);
        chk("t6_ready", 32'(bus.in_ready), 32'd0);
        check_map("t6_map");
        tick();
        chk("t6_idle_done", 32'(done_unpool), 32'd0);
        chk("t6_idle_ready", 32'(bus.in_ready), 32'd0);

        // Asynchronous reset in the middle of a frame
        start_frame();
        for (int b = 0; b < 3; b++) beat(DW'($urandom_range(1, 65535)), 2'($urandom));
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("t1_ready", 32'(bus.in_ready), 32'd0);
        chk("t1_done", 32'(done_unpool), 32'd0);
        check_map("t1_map");
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t1_after_ready", 32'(bus.in_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
